// File: rtl/sha_1_msg_ctrl.sv
// SHA-1 message sequencer: packs a 32-bit word stream into 512-bit blocks, applies
// padding plus the 64-bit bit-length, issues blocks to the iterative core and returns the digest.
module sha_1_msg_ctrl #(
  parameter int CORE_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  input  logic         abort,
  output logic [511:0] core_data,
  output logic [63:0]  core_index,
  output logic         core_enable,
  input  logic [159:0] core_hash,
  input  logic         core_ready,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         error
);

  localparam int WDW = $clog2(CORE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND, WAIT} state_t;

  state_t           state;
  logic [15:0][31:0] blk;
  logic [3:0]       p;
  logic [63:0]      byte_cnt;
  logic [WDW-1:0]   wd;
  logic             final_blk, need_extra, spill;

  logic        hs, k4;
  logic [3:0]  p1;
  logic [4:0]  pad_slot;
  logic [63:0] cnt_base, cnt_nxt, len_nxt, len_cur;
  logic [31:0] pad_word;

  assign hs       = in_valid & in_ready;
  assign k4       = in_bytes >= 3'd4;
  assign p1       = p + 4'd1;
  assign pad_slot = {1'b0, p} + {4'd0, k4};
  // A new message restarts the byte count from zero on its first word
  assign cnt_base = (state == IDLE) ? 64'd0 : byte_cnt;
  assign cnt_nxt  = cnt_base + (in_last ? (k4 ? 64'd4 : {61'd0, in_bytes}) : 64'd4);
  assign len_nxt  = {cnt_nxt[60:0], 3'b000};
  assign len_cur  = {byte_cnt[60:0], 3'b000};
  assign pad_word = (in_data & ~(32'hffff_ffff >> {in_bytes[1:0], 3'b000}))
                  | (32'h8000_0000 >> {in_bytes[1:0], 3'b000});
  assign core_data = blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      blk          <= '0;
      p            <= '0;
      byte_cnt     <= '0;
      wd           <= '0;
      final_blk    <= 1'b0;
      need_extra   <= 1'b0;
      spill        <= 1'b0;
      in_ready     <= 1'b1;
      core_index   <= '0;
      core_enable  <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      core_enable  <= 1'b0;
      digest_valid <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        p          <= '0;
        byte_cnt   <= '0;
        wd         <= '0;
        core_index <= '0;
        final_blk  <= 1'b0;
        need_extra <= 1'b0;
        spill      <= 1'b0;
        in_ready   <= 1'b1;
        busy       <= 1'b0;
        error      <= 1'b0;
      end else begin
        case (state)
          IDLE, FILL: if (hs) begin
            if (state == IDLE) begin
              core_index <= '0;
              busy       <= 1'b1;
            end
            byte_cnt <= cnt_nxt;
            if (!in_last) begin
              blk[p] <= in_data;
              p      <= p1;
              if (p == 4'd15) begin
                state      <= SEND;
                in_ready   <= 1'b0;
                final_blk  <= 1'b0;
                need_extra <= 1'b0;
              end else begin
                state <= FILL;
              end
            end else begin
              for (int j = 0; j < 16; j++)
                if (j > int'(p)) blk[j] <= '0;
              blk[p] <= k4 ? in_data : pad_word;
              if (k4 && p != 4'd15) blk[p1] <= 32'h8000_0000;
              // Length fits only if the 0x80 byte landed at or before word 13
              if (pad_slot <= 5'd13) begin
                blk[14]    <= len_nxt[63:32];
                blk[15]    <= len_nxt[31:0];
                final_blk  <= 1'b1;
                need_extra <= 1'b0;
              end else begin
                final_blk  <= 1'b0;
                need_extra <= 1'b1;
              end
              spill    <= pad_slot == 5'd16;
              state    <= SEND;
              in_ready <= 1'b0;
            end
          end
          SEND: begin
            core_enable <= 1'b1;
            wd          <= '0;
            state       <= WAIT;
          end
          WAIT: begin
            if (core_ready) begin
              if (final_blk) begin
                digest       <= core_hash;
                digest_valid <= 1'b1;
                busy         <= 1'b0;
                p            <= '0;
                in_ready     <= 1'b1;
                state        <= IDLE;
              end else if (need_extra) begin
                blk        <= '0;
                blk[0]     <= spill ? 32'h8000_0000 : 32'h0;
                blk[14]    <= len_cur[63:32];
                blk[15]    <= len_cur[31:0];
                final_blk  <= 1'b1;
                need_extra <= 1'b0;
                core_index <= core_index + 64'd1;
                state      <= SEND;
              end else begin
                core_index <= core_index + 64'd1;
                p          <= '0;
                in_ready   <= 1'b1;
                state      <= FILL;
              end
            end else if (wd == WDW'(CORE_TIMEOUT - 1)) begin
              // Hung core: stay locked out of new messages until abort
              error    <= 1'b1;
              busy     <= 1'b0;
              p        <= '0;
              in_ready <= 1'b0;
              state    <= IDLE;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_1_msg_ctrl.sv
// Bench for sha_1_msg_ctrl: a behavioural SHA-1 core answers core_enable, and a
// scoreboard of padded blocks and digests is checked as the controller emits them.
module tb_sha_1_msg_ctrl;

  localparam int LAT = 6;
  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, in_last = 1'b0, abort = 1'b0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic [511:0] core_data;
  logic [63:0]  core_index;
  logic         core_enable, core_ready = 1'b0;
  logic [159:0] core_hash = '0, digest;
  logic         digest_valid, busy, error;

  sha_1_msg_ctrl #(.CORE_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes), .abort(abort), .core_data(core_data),
    .core_index(core_index), .core_enable(core_enable), .core_hash(core_hash),
    .core_ready(core_ready), .digest(digest), .digest_valid(digest_valid),
    .busy(busy), .error(error));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rdy_cyc = 0, en_cyc = 0, err_cyc = -1, viol = 0, ndig = 0, resp = 0;
  bit hold_core = 0, in_wait = 0;
  logic [159:0] cur_h, pend_h;
  logic [511:0] exp_blk_q[$];
  logic [63:0]  exp_idx_q[$];
  logic [159:0] exp_dig_q[$];
  logic [511:0] seen_blk[$];
  logic [63:0]  seen_idx[$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] sha1_blk(input logic [159:0] hin, input logic [511:0] b);
    logic [31:0] w [80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[32*i +: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, bb, c, d, e} = hin;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = bb ^ c ^ d;                    k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + bb, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Core model plus output monitor, all sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    core_ready = 1'b0;
    if (rst) begin
      resp = 0;
      in_wait = 0;
    end else begin
      if (in_wait && in_ready) viol++;
      if (resp > 0) begin
        resp--;
        if (resp == 0) begin
          core_ready = 1'b1;
          core_hash  = pend_h;
          rdy_cyc    = cyc;
          in_wait    = 0;
        end
      end
      if (core_enable) begin
        seen_blk.push_back(core_data);
        seen_idx.push_back(core_index);
        en_cyc = cyc;
        if (exp_blk_q.size() == 0) chk("unexpected_enable", 1, 0);
        else begin
          chk("blk_data", core_data, exp_blk_q.pop_front());
          chk("blk_index", core_index, exp_idx_q.pop_front());
        end
        pend_h = sha1_blk((core_index == 64'd0) ? IV : cur_h, core_data);
        cur_h  = pend_h;
        resp   = hold_core ? 0 : LAT;
        in_wait = 1;
      end
      if (digest_valid) begin
        ndig++;
        chk("dv_latency", cyc - rdy_cyc, 1);
        if (exp_dig_q.size() == 0) chk("unexpected_digest", 1, 0);
        else chk("digest", digest, exp_dig_q.pop_front());
      end
      if (error && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic put(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    @(negedge clk);
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input byte unsigned m[$], input byte unsigned fill, input bit push_dig,
                          input bit use_known, input logic [159:0] known);
    byte unsigned pq[$];
    logic [511:0] bv;
    logic [159:0] h;
    logic [63:0]  bitlen;
    logic [31:0]  wv;
    int n, nw, k, a;
    n = m.size();
    pq = m;
    pq.push_back(8'h80);
    while (pq.size() % 64 != 56) pq.push_back(8'h00);
    bitlen = 64'(n) * 64'd8;
    for (int i = 7; i >= 0; i--) pq.push_back(bitlen[8*i +: 8]);
    h = IV;
    for (int b = 0; b < pq.size() / 64; b++) begin
      for (int i = 0; i < 16; i++) begin
        a = 64*b + 4*i;
        bv[32*i +: 32] = {pq[a], pq[a+1], pq[a+2], pq[a+3]};
      end
      exp_blk_q.push_back(bv);
      exp_idx_q.push_back(64'(b));
      h = sha1_blk(h, bv);
    end
    if (push_dig) exp_dig_q.push_back(use_known ? known : h);
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++)
        wv[31-8*j -: 8] = (4*w + j < n) ? m[4*w + j] : fill;
      k = (w == nw - 1) ? n - 4*(nw - 1) : 4;
      put(wv, w == nw - 1, 3'(k));
    end
  endtask

  task automatic send_str(input string s, input byte unsigned fill, input bit push_dig,
                          input bit use_known, input logic [159:0] known);
    byte unsigned q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_msg(q, fill, push_dig, use_known, known);
  endtask

  task automatic wait_dig(input string tag);
    int s = ndig, n = 0;
    while (ndig == s && n < 3000) begin @(negedge clk); n++; end
    if (ndig == s) chk(tag, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_enable(input int cnt);
    int n = 0;
    while (seen_blk.size() < cnt && n < 3000) begin @(negedge clk); n++; end
    if (seen_blk.size() < cnt) chk("enable_timeout", seen_blk.size(), cnt);
  endtask

  localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_56    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  initial begin
    byte unsigned q[$];
    int d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_enable", core_enable, 0);
    chk("rst_dv", digest_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_digest", digest, 0);
    chk("rst_index", core_index, 0);
    chk("rst_core_data", core_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // "abc"
    seen_blk.delete(); seen_idx.delete();
    send_str("abc", 8'h00, 1, 1, D_ABC);
    wait_dig("abc_timeout");
    chk("abc_nen", seen_blk.size(), 1);
    chk("abc_idx", seen_idx[0], 0);
    chk("abc_w0", seen_blk[0][31:0], 32'h61626380);
    chk("abc_w15", seen_blk[0][511:480], 32'h18);
    chk("abc_busy_done", busy, 0);

    // empty message, junk in the unused bytes must be masked
    seen_blk.delete(); seen_idx.delete();
    q.delete();
    send_msg(q, 8'ha5, 1, 1, D_EMPTY);
    wait_dig("empty_timeout");
    chk("empty_nen", seen_blk.size(), 1);
    chk("empty_w0", seen_blk[0][31:0], 32'h80000000);
    chk("empty_w15", seen_blk[0][511:480], 32'h0);

    // 56 bytes: 0x80 lands in word 14, length goes into an extra block
    seen_blk.delete(); seen_idx.delete();
    send_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h00, 1, 1, D_56);
    wait_dig("m56_timeout");
    chk("m56_nen", seen_blk.size(), 2);
    chk("m56_idx1", seen_idx[1], 1);
    chk("m56_b0w14", seen_blk[0][479:448], 32'h80000000);
    chk("m56_b1w15", seen_blk[1][511:480], 32'h1c0);

    // 64 bytes: 0x80 spills into word 0 of the extra block
    seen_blk.delete(); seen_idx.delete();
    viol = 0;
    send_str("0123456789abcdefFEDCBA9876543210qwertyuiopasdfghjklzxcvbnm!@#$%^", 8'h00, 1, 0, '0);
    wait_dig("m64_timeout");
    chk("m64_nen", seen_blk.size(), 2);
    chk("m64_b1w0", seen_blk[1][31:0], 32'h80000000);
    chk("m64_b1w15", seen_blk[1][511:480], 32'h200);
    chk("m64_ready_in_wait", viol, 0);

    // watchdog
    seen_blk.delete(); seen_idx.delete();
    hold_core = 1; err_cyc = -1;
    send_str("abc", 8'h00, 0, 0, '0);
    begin
      int n = 0;
      while (err_cyc < 0 && n < 600) begin @(negedge clk); n++; end
    end
    chk("wd_error", error, 1);
    chk("wd_busy", busy, 0);
    d = err_cyc - en_cyc;
    chk("wd_cycles", (d >= 254 && d <= 256), 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h11223344;
    repeat (3) @(negedge clk);
    chk("wd_reject", in_ready, 0);
    chk("wd_no_enable", seen_blk.size(), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    hold_core = 0;
    chk("abort_clr_error", error, 0);
    chk("abort_in_ready", in_ready, 1);

    // abort mid-FILL, then "abc"
    seen_blk.delete(); seen_idx.delete();
    for (int i = 0; i < 5; i++) put(32'hdead0000 + 32'(i), 1'b0, 3'd4);
    chk("fill_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    send_str("abc", 8'h00, 1, 1, D_ABC);
    wait_dig("post_abort_timeout");
    chk("post_abort_nen", seen_blk.size(), 1);
    chk("post_abort_idx", seen_idx[0], 0);

    // asynchronous reset while waiting on the core
    seen_blk.delete(); seen_idx.delete();
    hold_core = 1;
    send_str("abc", 8'h00, 0, 0, '0);
    wait_enable(1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_digest", digest, 0);
    chk("arst_core_data", core_data, 0);
    chk("arst_index", core_index, 0);
    chk("arst_error", error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_core = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("blk_q_left", exp_blk_q.size(), 0);
    chk("dig_q_left", exp_dig_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
